// File: rtl/emesh_rd_resp.sv
// -----------------------------------------------------------------------------
// emesh_rd_resp
//   Emesh memory slave. Inbound emesh transactions are queued in a small
//   request FIFO and executed strictly in order against a synchronous
//   single-port memory (read data one cycle after the enable). A write is
//   retired in its pop cycle with no response. A read produces one emesh
//   write transaction back to the requester's srcaddr, carrying the read data
//   right-justified.
//
// Ports
//   eclk, reset              clock (rising edge) / async active-high reset
//   emesh_*_inb              inbound transaction (access qualifies)
//   emesh_rd_wait_outb       backpressure to inbound requester (FIFO full)
//   emesh_*_outb             read-response transaction
//   emesh_wr_wait_inb        stall on the response path
//   mem_en/we/addr/wdata     memory request (driven in the pop cycle)
//   mem_rdata                memory read data, valid one cycle after mem_en
// -----------------------------------------------------------------------------
module emesh_rd_resp #(
  parameter int MAW = 10,
  parameter int RFW = 2
) (
  input  logic            eclk,
  input  logic            reset,
  // inbound request
  input  logic            emesh_access_inb,
  input  logic            emesh_write_inb,
  input  logic [1:0]      emesh_datamode_inb,
  input  logic [3:0]      emesh_ctrlmode_inb,
  input  logic [31:0]     emesh_dstaddr_inb,
  input  logic [31:0]     emesh_srcaddr_inb,
  input  logic [31:0]     emesh_data_inb,
  output logic            emesh_rd_wait_outb,
  // outbound response
  output logic            emesh_access_outb,
  output logic            emesh_write_outb,
  output logic [1:0]      emesh_datamode_outb,
  output logic [3:0]      emesh_ctrlmode_outb,
  output logic [31:0]     emesh_dstaddr_outb,
  output logic [31:0]     emesh_srcaddr_outb,
  output logic [31:0]     emesh_data_outb,
  input  logic            emesh_wr_wait_inb,
  // memory port
  output logic            mem_en,
  output logic [3:0]      mem_we,
  output logic [MAW-1:0]  mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata
);

  localparam int             DEPTH   = 2 ** RFW;
  localparam logic [RFW:0]   DEPTH_C = DEPTH[RFW:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RDLAT = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  datamode;
    logic [3:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [31:0] srcaddr;
    logic [31:0] data;
  } req_t;

  // Byte enables for a write: byte lane from addr[1:0], half from addr[1];
  // word and double both write the whole 32-bit word.
  function automatic logic [3:0] write_be_f(input logic [1:0] dm, input logic [1:0] a);
    logic [3:0] be;
    case (dm)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the write data on every lane so the byte enables pick the lane.
  function automatic logic [31:0] write_data_f(input logic [1:0] dm, input logic [31:0] d);
    logic [31:0] w;
    case (dm)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Right-justify the addressed lane of a read word, zero-filling above it.
  function automatic logic [31:0] read_extract_f(input logic [1:0] dm, input logic [1:0] a,
                                                 input logic [31:0] w);
    logic [31:0] r;
    case (dm)
      2'b00:   r = {24'h000000, w[8*a +: 8]};
      2'b01:   r = {16'h0000, (a[1] ? w[31:16] : w[15:0])};
      default: r = w;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  req_t             fifo_r [DEPTH];
  logic [RFW-1:0]   wr_ptr_r;
  logic [RFW-1:0]   rd_ptr_r;
  logic [RFW:0]     count_r;
  logic [RFW:0]     count_nxt_s;
  logic             full_r;
  logic             push_s;
  logic             pop_s;
  req_t             head_s;
  req_t             in_req_s;

  state_t           state_r;

  assign in_req_s = '{write:    emesh_write_inb,
                      datamode: emesh_datamode_inb,
                      ctrlmode: emesh_ctrlmode_inb,
                      dstaddr:  emesh_dstaddr_inb,
                      srcaddr:  emesh_srcaddr_inb,
                      data:     emesh_data_inb};

  // The full flag is registered, so an access seen while it is high is simply
  // not pushed; the requester keeps presenting it.
  assign push_s = emesh_access_inb & ~full_r;
  assign pop_s  = (state_r == IDLE) & (count_r != {(RFW+1){1'b0}});
  assign head_s = fifo_r[rd_ptr_r];

  assign emesh_rd_wait_outb = full_r;

  // Next occupancy: push and pop together cancel out.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + (RFW+1)'(1);
      2'b01:   count_nxt_s = count_r - (RFW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO pointers, occupancy and the registered full flag.
  always_ff @(posedge eclk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {RFW{1'b0}};
      rd_ptr_r <= {RFW{1'b0}};
      count_r  <= {(RFW+1){1'b0}};
      full_r   <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + RFW'(1);
      else        wr_ptr_r <= wr_ptr_r;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + RFW'(1);
      else        rd_ptr_r <= rd_ptr_r;
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
    end
  end

  // FIFO entry storage.
  always_ff @(posedge eclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) fifo_r[i] <= '0;
    end else if (push_s) begin
      fifo_r[wr_ptr_r] <= in_req_s;
    end else begin
      fifo_r[wr_ptr_r] <= fifo_r[wr_ptr_r];
    end
  end

  // ---------------------------------------------------------------------------
  // Memory request: issued in the pop cycle straight from the FIFO head so the
  // read data lands one cycle later, in RDLAT. Zero whenever nothing pops.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = {MAW{1'b0}};
    mem_wdata = 32'h0000_0000;
    if (pop_s) begin
      mem_en   = 1'b1;
      mem_addr = head_s.dstaddr[MAW+1:2];
      if (head_s.write) begin
        mem_we    = write_be_f(head_s.datamode, head_s.dstaddr[1:0]);
        mem_wdata = write_data_f(head_s.datamode, head_s.data);
      end else begin
        mem_we    = 4'b0000;
        mem_wdata = 32'h0000_0000;
      end
    end else begin
      mem_en = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Execution FSM and registered response outputs
  // ---------------------------------------------------------------------------
  logic [31:0] req_src_r;
  logic [1:0]  req_dm_r;
  logic [3:0]  req_cm_r;
  logic [1:0]  req_lane_r;

  // Sequences pops; a read parks its request fields until the response forms.
  always_ff @(posedge eclk or posedge reset) begin
    if (reset) begin
      state_r             <= IDLE;
      req_src_r           <= 32'h0000_0000;
      req_dm_r            <= 2'b00;
      req_cm_r            <= 4'b0000;
      req_lane_r          <= 2'b00;
      emesh_access_outb   <= 1'b0;
      emesh_write_outb    <= 1'b0;
      emesh_datamode_outb <= 2'b00;
      emesh_ctrlmode_outb <= 4'b0000;
      emesh_dstaddr_outb  <= 32'h0000_0000;
      emesh_srcaddr_outb  <= 32'h0000_0000;
      emesh_data_outb     <= 32'h0000_0000;
    end else begin
      emesh_srcaddr_outb <= 32'h0000_0000;
      case (state_r)
        IDLE: begin
          if (pop_s && !head_s.write) begin
            req_src_r  <= head_s.srcaddr;
            req_dm_r   <= head_s.datamode;
            req_cm_r   <= head_s.ctrlmode;
            req_lane_r <= head_s.dstaddr[1:0];
            state_r    <= RDLAT;
          end else begin
            // Writes retire in their pop cycle; stay here.
            state_r <= IDLE;
          end
        end
        RDLAT: begin
          emesh_data_outb     <= read_extract_f(req_dm_r, req_lane_r, mem_rdata);
          emesh_dstaddr_outb  <= req_src_r;
          emesh_datamode_outb <= req_dm_r;
          emesh_ctrlmode_outb <= req_cm_r;
          emesh_write_outb    <= 1'b1;
          emesh_access_outb   <= 1'b1;
          state_r             <= RESP;
        end
        RESP: begin
          if (!emesh_wr_wait_inb) begin
            emesh_access_outb <= 1'b0;
            emesh_write_outb  <= 1'b0;
            state_r           <= IDLE;
          end else begin
            // Stalled: every response register simply holds.
            state_r <= RESP;
          end
        end
        default: begin
          emesh_access_outb <= 1'b0;
          emesh_write_outb  <= 1'b0;
          state_r           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_emesh_rd_resp.sv
// -----------------------------------------------------------------------------
// tb_emesh_rd_resp
//   Randomized bench for emesh_rd_resp. A behavioural model keeps a shadow
//   byte-addressed memory, applies each accepted request in acceptance order,
//   and queues the expected memory operations and read responses.
// -----------------------------------------------------------------------------
module tb_emesh_rd_resp;

  localparam int MAW = 10;
  localparam int RFW = 2;
  localparam int MWORDS = 1 << MAW;

  logic            eclk = 1'b0;
  logic            reset;
  logic            emesh_access_inb, emesh_write_inb;
  logic [1:0]      emesh_datamode_inb;
  logic [3:0]      emesh_ctrlmode_inb;
  logic [31:0]     emesh_dstaddr_inb, emesh_srcaddr_inb, emesh_data_inb;
  logic            emesh_rd_wait_outb;
  logic            emesh_access_outb, emesh_write_outb;
  logic [1:0]      emesh_datamode_outb;
  logic [3:0]      emesh_ctrlmode_outb;
  logic [31:0]     emesh_dstaddr_outb, emesh_srcaddr_outb, emesh_data_outb;
  logic            emesh_wr_wait_inb;
  logic            mem_en;
  logic [3:0]      mem_we;
  logic [MAW-1:0]  mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;

  emesh_rd_resp #(.MAW(MAW), .RFW(RFW)) dut (
    .eclk(eclk), .reset(reset),
    .emesh_access_inb(emesh_access_inb), .emesh_write_inb(emesh_write_inb),
    .emesh_datamode_inb(emesh_datamode_inb), .emesh_ctrlmode_inb(emesh_ctrlmode_inb),
    .emesh_dstaddr_inb(emesh_dstaddr_inb), .emesh_srcaddr_inb(emesh_srcaddr_inb),
    .emesh_data_inb(emesh_data_inb), .emesh_rd_wait_outb(emesh_rd_wait_outb),
    .emesh_access_outb(emesh_access_outb), .emesh_write_outb(emesh_write_outb),
    .emesh_datamode_outb(emesh_datamode_outb), .emesh_ctrlmode_outb(emesh_ctrlmode_outb),
    .emesh_dstaddr_outb(emesh_dstaddr_outb), .emesh_srcaddr_outb(emesh_srcaddr_outb),
    .emesh_data_outb(emesh_data_outb), .emesh_wr_wait_inb(emesh_wr_wait_inb),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 eclk = ~eclk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- memory stub (synchronous, one-cycle read) ---------------
  logic [31:0] mem_sim [MWORDS];

  always @(posedge eclk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we == 4'b0000) mem_rdata <= mem_sim[mem_addr];
      else
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) mem_sim[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // ---------------- reference model ----------------------------------------
  typedef struct { logic [3:0] we; logic [31:0] addr; logic [31:0] wdata; } mop_t;
  typedef struct { logic [31:0] dst; logic [31:0] data; logic [1:0] dm; logic [3:0] cm; } rsp_t;

  byte unsigned model_mem [MWORDS*4];
  mop_t mop_q[$];
  rsp_t rsp_q[$];
  int   pop_cyc_q[$];

  task automatic model_accept(input logic w, input logic [1:0] dm, input logic [3:0] cm,
                              input logic [31:0] dst, input logic [31:0] src, input logic [31:0] d);
    int unsigned widx, base, first, nbytes, lane;
    mop_t m;
    rsp_t r;
    widx = (dst / 4) % MWORDS;
    base = widx * 4;
    lane = dst % 4;
    // Bytes touched: one byte, an aligned half (by address bit 1), or all four.
    if (dm == 2'd0)      begin first = lane;              nbytes = 1; end
    else if (dm == 2'd1) begin first = (lane / 2) * 2;    nbytes = 2; end
    else                 begin first = 0;                 nbytes = 4; end
    if (w) begin
      m.we = 4'd0;
      for (int k = 0; k < nbytes; k++) begin
        m.we[first + k] = 1'b1;
        model_mem[base + first + k] = d[8*k +: 8];
      end
      if (dm == 2'd0)      m.wdata = (d & 32'hFF) * 32'h0101_0101;
      else if (dm == 2'd1) m.wdata = (d & 32'hFFFF) * 32'h0001_0001;
      else                 m.wdata = d;
      m.addr = widx;
      mop_q.push_back(m);
    end else begin
      m.we = 4'd0; m.addr = widx; m.wdata = 32'd0;
      mop_q.push_back(m);
      r.data = 32'd0;
      for (int k = 0; k < nbytes; k++)
        r.data = r.data | (32'(model_mem[base + first + k]) << (8*k));
      r.dst = src; r.dm = dm; r.cm = cm;
      rsp_q.push_back(r);
    end
  endtask

  task automatic preload(input int widx, input logic [31:0] v);
    mem_sim[widx] = v;
    for (int k = 0; k < 4; k++) model_mem[widx*4 + k] = v[8*k +: 8];
  endtask

  // ---------------- monitor ------------------------------------------------
  logic prev_access = 1'b0;

  always @(negedge eclk) begin
    if (!reset) begin
      if (mem_en) begin
        if (mop_q.size() == 0) check_val("spurious_mem_en", 32'(mem_en), 32'd0);
        else begin
          mop_t m;
          m = mop_q.pop_front();
          check_val("mem_we", 32'(mem_we), 32'(m.we));
          check_val("mem_addr", 32'(mem_addr), m.addr);
          if (m.we != 4'd0) check_val("mem_wdata", mem_wdata, m.wdata);
          else pop_cyc_q.push_back(cyc);
        end
      end else begin
        check_val("mem_we_idle", 32'(mem_we), 32'd0);
      end
      if (emesh_access_outb) begin
        if (rsp_q.size() == 0) check_val("spurious_access_outb", 32'(emesh_access_outb), 32'd0);
        else begin
          rsp_t r;
          r = rsp_q[0];
          check_val("rsp_dstaddr", emesh_dstaddr_outb, r.dst);
          check_val("rsp_data", emesh_data_outb, r.data);
          check_val("rsp_datamode", 32'(emesh_datamode_outb), 32'(r.dm));
          check_val("rsp_ctrlmode", 32'(emesh_ctrlmode_outb), 32'(r.cm));
          check_val("rsp_write", 32'(emesh_write_outb), 32'd1);
          check_val("rsp_srcaddr", emesh_srcaddr_outb, 32'd0);
          if (!prev_access && pop_cyc_q.size() > 0)
            check_val("rsp_latency", 32'(cyc - pop_cyc_q.pop_front()), 32'd2);
          if (!emesh_wr_wait_inb) void'(rsp_q.pop_front());
        end
      end
      prev_access = emesh_access_outb;
    end else begin
      prev_access = 1'b0;
    end
  end

  // ---------------- driver -------------------------------------------------
  task automatic send(input logic w, input logic [1:0] dm, input logic [3:0] cm,
                      input logic [31:0] dst, input logic [31:0] src, input logic [31:0] d);
    logic acc = 1'b0;
    int tries = 0;
    emesh_access_inb = 1'b1; emesh_write_inb = w; emesh_datamode_inb = dm;
    emesh_ctrlmode_inb = cm; emesh_dstaddr_inb = dst; emesh_srcaddr_inb = src;
    emesh_data_inb = d;
    while (!acc && tries < 300) begin
      @(negedge eclk);
      acc = !emesh_rd_wait_outb;
      @(posedge eclk); #1;
      tries++;
    end
    if (!acc) check_val("send_timeout", 32'(tries), 32'd0);
    else model_accept(w, dm, cm, dst, src, d);
    emesh_access_inb = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((rsp_q.size() != 0 || mop_q.size() != 0) && t < 500) begin
      @(posedge eclk); #1; t++;
    end
    check_val(tag, 32'(rsp_q.size() + mop_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic rand_done;

  initial begin
    reset = 1'b1; emesh_access_inb = 1'b0; emesh_write_inb = 1'b0;
    emesh_datamode_inb = 2'd0; emesh_ctrlmode_inb = 4'd0; emesh_dstaddr_inb = 32'd0;
    emesh_srcaddr_inb = 32'd0; emesh_data_inb = 32'd0; emesh_wr_wait_inb = 1'b0;
    mem_rdata = 32'd0;
    for (int i = 0; i < MWORDS; i++) preload(i, $urandom);
    preload(4, 32'hDEAD_BEEF);
    preload(1, 32'h1234_5678);

    repeat (3) @(posedge eclk);
    #1;
    check_val("rst_access_outb", 32'(emesh_access_outb), 32'd0);
    check_val("rst_rd_wait", 32'(emesh_rd_wait_outb), 32'd0);
    check_val("rst_mem_en", 32'(mem_en), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_mem_wdata", mem_wdata, 32'd0);
    check_val("rst_data_outb", emesh_data_outb, 32'd0);
    check_val("rst_dstaddr_outb", emesh_dstaddr_outb, 32'd0);
    @(negedge eclk); reset = 1'b0;
    @(posedge eclk); #1;

    // Directed: word read, byte write + read back, hword read.
    send(1'b0, 2'd2, 4'h3, 32'h10, 32'h810F_0081, 32'd0);
    send(1'b1, 2'd0, 4'h0, 32'h21, 32'h0000_0001, 32'h0000_00AB);
    send(1'b0, 2'd0, 4'h5, 32'h21, 32'h0000_0002, 32'd0);
    send(1'b0, 2'd1, 4'h0, 32'h06, 32'h0000_0003, 32'd0);
    send(1'b0, 2'd3, 4'hA, 32'h10, 32'h0000_0004, 32'd0);
    drain("drain_directed");
    check_val("directed_bytewrite_word8", (mem_sim[8] >> 8) & 32'hFF, 32'h0000_00AB);

    // Back-to-back reads with the response path stalled until the FIFO fills.
    emesh_wr_wait_inb = 1'b1;
    for (int i = 0; i < 5; i++) send(1'b0, 2'd2, 4'(i), 32'(4*i), 32'h100 + 32'(i), 32'd0);
    @(negedge eclk);
    check_val("stall_rd_wait_full", 32'(emesh_rd_wait_outb), 32'd1);
    @(posedge eclk); #1;
    fork
      send(1'b0, 2'd2, 4'h7, 32'h40, 32'h200, 32'd0);
      begin
        repeat (8) @(posedge eclk);
        @(negedge eclk);
        check_val("stall_held_rd_wait", 32'(emesh_rd_wait_outb), 32'd1);
        @(posedge eclk); #1;
        emesh_wr_wait_inb = 1'b0;
      end
    join
    drain("drain_stall");

    // Randomized mix of reads and writes with random response stalls.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++)
          send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
               32'($urandom_range(0, 63)), $urandom, $urandom);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge eclk); #1;
          emesh_wr_wait_inb = ($urandom_range(0, 2) == 0);
        end
      end
    join
    emesh_wr_wait_inb = 1'b0;
    drain("drain_random");

    // Reset while a response is stalled with three more reads queued.
    emesh_wr_wait_inb = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, 2'd2, 4'd0, 32'(8*i), 32'h300 + 32'(i), 32'd0);
    begin
      int t = 0;
      while (!emesh_access_outb && t < 20) begin @(negedge eclk); t++; end
      check_val("pre_reset_in_resp", 32'(emesh_access_outb), 32'd1);
    end
    @(negedge eclk); #2;
    reset = 1'b1;
    #1;
    check_val("midrst_access_outb", 32'(emesh_access_outb), 32'd0);
    check_val("midrst_rd_wait", 32'(emesh_rd_wait_outb), 32'd0);
    check_val("midrst_mem_en", 32'(mem_en), 32'd0);
    rsp_q.delete(); mop_q.delete(); pop_cyc_q.delete();
    emesh_wr_wait_inb = 1'b0;
    @(posedge eclk); @(negedge eclk); #2;
    reset = 1'b0;
    repeat (20) @(posedge eclk);
    #1;
    check_val("post_rst_access_outb", 32'(emesh_access_outb), 32'd0);
    check_val("post_rst_rd_wait", 32'(emesh_rd_wait_outb), 32'd0);

    // Queue still works after the reset.
    send(1'b0, 2'd2, 4'h1, 32'h10, 32'h400, 32'd0);
    drain("drain_post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
